mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 13 +
 rtl/mem_wb_stage_data_mem.sv | 27 ++
 rtl/mem_wb_stage.sv | 88 ++++++++
 tb/tb_mem_wb_stage.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared processor constants and alignment helper
package mem_wb_stage_pkg;

  localparam int DATA_W        = 32;
  localparam int REG_W         = 5;
  localparam int DEFAULT_DEPTH = 64;

  // A memory access is misaligned when it targets a non-word-aligned byte address
  function automatic logic is_misaligned(input logic [1:0] byte_offset, input logic access);
    return access && (byte_offset != 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// rtl/mem_wb_stage_data_mem.sv - word-addressed data memory with combinational read
module data_mem
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  // Contents start at zero at time zero and are never cleared by reset
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  // Single write port; the caller already gates misaligned stores and reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wd;
    end
  end

  assign rd = mem_q[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access stage plus MEM/WB pipeline register
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_W-1:0]  WriteRegM,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemToRegM,
  output logic              AddrErrM,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [REG_W-1:0]  WriteRegW,
  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic [DATA_W-1:0] ResultW
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     word_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  // W-stage registers; zero at time zero so outputs are defined before the first reset
  logic [DATA_W-1:0] alu_out_q    = '0;
  logic [DATA_W-1:0] read_data_q  = '0;
  logic [REG_W-1:0]  write_reg_q  = '0;
  logic              reg_write_q  = 1'b0;
  logic              mem_to_reg_q = 1'b0;
  logic [DATA_W-1:0] alu_out_d;
  logic [DATA_W-1:0] read_data_d;
  logic [REG_W-1:0]  write_reg_d;
  logic              reg_write_d;
  logic              mem_to_reg_d;

  // Upper address bits are ignored so accesses wrap modulo the memory size
  assign word_addr = ALUOutM[AW+1:2];
  assign AddrErrM  = is_misaligned(ALUOutM[1:0], MemWriteM | MemToRegM);
  assign mem_we    = MemWriteM & ~AddrErrM & ~reset;

  data_mem #(.DEPTH(DEPTH)) u_data_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (word_addr),
    .wd   (WriteDataM),
    .rd   (mem_rd)
  );

  // Next W-stage values; a misaligned load is squashed so it never writes the register file
  always_comb begin
    alu_out_d    = ALUOutM;
    read_data_d  = mem_rd;
    write_reg_d  = WriteRegM;
    reg_write_d  = RegWriteM & ~(MemToRegM & AddrErrM);
    mem_to_reg_d = MemToRegM;
  end

  // MEM/WB pipeline register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_q    <= '0;
      read_data_q  <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      alu_out_q    <= alu_out_d;
      read_data_q  <= read_data_d;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign ALUOutW   = alu_out_q;
  assign ReadDataW = read_data_q;
  assign WriteRegW = write_reg_q;
  assign RegWriteW = reg_write_q;
  assign MemToRegW = mem_to_reg_q;
  assign ResultW   = mem_to_reg_q ? read_data_q : alu_out_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ALUOutM = '0;
  logic [31:0] WriteDataM = '0;
  logic [4:0]  WriteRegM = '0;
  logic        RegWriteM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic        MemToRegM = 1'b0;
  logic        AddrErrM;
  logic [31:0] ALUOutW;
  logic [31:0] ReadDataW;
  logic [4:0]  WriteRegW;
  logic        RegWriteW;
  logic        MemToRegW;
  logic [31:0] ResultW;

  int tests = 0;
  int fails = 0;

  // Reference memory image: 64 words, zero at start
  logic [31:0] mref [64];

  mem_wb_stage #(.DEPTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .WriteRegM  (WriteRegM),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .MemToRegM  (MemToRegM),
    .AddrErrM   (AddrErrM),
    .ALUOutW    (ALUOutW),
    .ReadDataW  (ReadDataW),
    .WriteRegW  (WriteRegW),
    .RegWriteW  (RegWriteW),
    .MemToRegW  (MemToRegW),
    .ResultW    (ResultW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction through the stage: drive, check AddrErrM, clock, check W outputs
  task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] wr, input logic rw, input logic mw, input logic mtr);
    logic        mis;
    int          idx;
    logic [31:0] old_word;
    logic [31:0] e_alu, e_rd, e_res;
    logic [4:0]  e_wr;
    logic        e_rw, e_mtr;
    @(negedge clk);
    reset = rst; ALUOutM = a; WriteDataM = d; WriteRegM = wr;
    RegWriteM = rw; MemWriteM = mw; MemToRegM = mtr;
    #1;
    mis = ((a % 32'd4) != 0) && (mw || mtr);
    chk("addr_err", {31'b0, AddrErrM}, {31'b0, mis});
    idx = int'((a / 32'd4) % 32'd64);
    old_word = mref[idx];
    if (rst) begin
      e_alu = 0; e_rd = 0; e_wr = 0; e_rw = 0; e_mtr = 0;
    end else begin
      e_alu = a; e_rd = old_word; e_wr = wr; e_mtr = mtr;
      e_rw = rw && !(mtr && mis);
      if (mw && !mis) mref[idx] = d;
    end
    e_res = e_mtr ? e_rd : e_alu;
    @(posedge clk);
    #1;
    chk("alu_out_w", ALUOutW, e_alu);
    chk("read_data_w", ReadDataW, e_rd);
    chk("write_reg_w", {27'b0, WriteRegW}, {27'b0, e_wr});
    chk("reg_write_w", {31'b0, RegWriteW}, {31'b0, e_rw});
    chk("mem_to_reg_w", {31'b0, MemToRegW}, {31'b0, e_mtr});
    chk("result_w", ResultW, e_res);
  endtask

  initial begin
    logic [31:0] ra, rd;
    for (int i = 0; i < 64; i++) mref[i] = '0;

    // Time-zero state before any reset
    #1;
    chk("init_result", ResultW, 32'h0);
    chk("init_alu", ALUOutW, 32'h0);
    chk("init_regwrite", {31'b0, RegWriteW}, 32'h0);

    step(1, 32'h0, 32'h0, 5'd0, 0, 0, 0);

    // Aligned store then load
    step(0, 32'h10, 32'hDEADBEEF, 5'd0, 0, 1, 0);
    step(0, 32'h10, 32'h0, 5'd8, 1, 0, 1);
    chk("st_ld_readdata", ReadDataW, 32'hDEADBEEF);
    chk("st_ld_result", ResultW, 32'hDEADBEEF);
    chk("st_ld_regwrite", {31'b0, RegWriteW}, 32'h1);
    chk("st_ld_writereg", {27'b0, WriteRegW}, 32'd8);

    // Misaligned store is dropped
    step(0, 32'h12, 32'h12345678, 5'd0, 0, 1, 0);
    step(0, 32'h10, 32'h0, 5'd1, 1, 0, 1);
    chk("mis_st_prior", ResultW, 32'hDEADBEEF);

    // Misaligned load never writes the register file
    step(0, 32'h21, 32'h0, 5'd9, 1, 0, 1);
    chk("mis_ld_regwrite", {31'b0, RegWriteW}, 32'h0);

    // Wrap-around: 0x100 aliases 0x000 with 64 words
    step(0, 32'h100, 32'hA5A5A5A5, 5'd0, 0, 1, 0);
    step(0, 32'h0, 32'h0, 5'd2, 1, 0, 1);
    chk("wrap_result", ResultW, 32'hA5A5A5A5);

    // Reset mid-operation blocks the store and clears W
    step(1, 32'h4, 32'hFFFFFFFF, 5'd7, 1, 1, 0);
    chk("rst_result", ResultW, 32'h0);
    chk("rst_alu", ALUOutW, 32'h0);
    step(0, 32'h4, 32'h0, 5'd4, 1, 0, 1);
    chk("rst_word04", ResultW, 32'h0);
    step(0, 32'h10, 32'h0, 5'd4, 1, 0, 1);
    chk("rst_keep10", ResultW, 32'hDEADBEEF);
    step(0, 32'h0, 32'h0, 5'd4, 1, 0, 1);
    chk("rst_keep00", ResultW, 32'hA5A5A5A5);

    // ALU path
    step(0, 32'h7, 32'h0, 5'd3, 1, 0, 0);
    chk("alu_result", ResultW, 32'h7);
    chk("alu_writereg", {27'b0, WriteRegW}, 32'd3);

    // Randomised traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
      if ($urandom_range(0, 3) != 0) ra = ra & 32'hFFFF_FFFC;
      rd = $urandom;
      step(($urandom_range(0, 31) == 0), ra, rd, 5'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
